pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshakes, carry/borrow chaining, optional saturation and a full flag set. The carry chain is split into STAGES equal chunks, one chunk per pipeline stage, so wide datapaths close timing at full throughput. It is the arithmetic primitive under the accumulator and DSP datapath blocks.

## Interface
- N, default 32: operand/result width; must be a multiple of STAGES.
- STAGES, default 4: pipeline depth; chunk width C = N/STAGES; 1 <= STAGES <= N.
- TAG_W, default 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts when in_valid && in_ready.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in for ADC, or borrow-in for SBB (1 = borrow); ignored for ADD/SUB.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- sat_en  in  1  enable saturation.
- is_signed  in  1  saturation and overflow use two's-complement semantics.
- tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- result  out  N  final result, saturated when sat_en is set.
- carry_flag  out  1  ADD/ADC: carry out of bit N-1. SUB/SBB: borrow occurred (1 = borrow, active-high).
- ovf_flag  out  1  signed overflow of the raw result.
- zero_flag  out  1  result == 0.
- neg_flag  out  1  result[N-1].
- tag_out  out  TAG_W  tag of the result.

## Operation
- Subtraction is computed as a + ~b + 1. SBB is a + ~b + ~cin. ADC is a + b + cin.
- Internal carry c is 1 for no borrow; carry_flag = ~c for SUB/SBB.
- Stage k (0..STAGES-1) adds chunk k, bits [kC+C-1:kC], using the carry from stage k-1.
  - Lower result chunks propagate forward registered.
  - Upper operand chunks propagate forward registered (skewed).
  - op, sat_en, is_signed and tag travel with the data.
- ovf = carry into MSB XOR carry out of MSB, evaluated in the final stage.
- Saturation, applied in the final stage when sat_en is set:
  - Unsigned ADD/ADC with carry: result saturates to all-ones.
  - Unsigned SUB/SBB with borrow: result saturates to 0.
  - Signed with ovf: the raw MSB is 0 means negative overflow and the result saturates to 1<<(N-1); the raw MSB is 1 means positive overflow and the result saturates to (1<<(N-1))-1.
- carry_flag and ovf_flag always describe the raw result. zero_flag and neg_flag describe the final result.

## Timing
- Global advance enable: adv = ~out_valid | out_ready. in_ready = adv. All stage registers load only when adv is high.
- Latency: a result appears exactly STAGES cycles after acceptance, absent stalls.
- Throughput is one operation per cycle. Results are delivered in order. Bubbles do not collapse.
- While out_valid && !out_ready, result, all flags and tag_out hold stable.
- Reset (asynchronous, immediate) sets every stage valid bit, out_valid and all outputs to 0. in_ready reads 1 after reset.
- Asserting rst mid-operation discards all in-flight operations; none are emitted after reset release.
- STAGES = 1 gives a single registered stage with latency 1.

## Structure
- Package addsub_pkg holds:
  - typedef enum logic [1:0] op_t {OP_ADD, OP_SUB, OP_ADC, OP_SBB}.
  - the function sat_value(raw, c, ovf, op, is_signed).
- Sub-module addsub_chunk (parameter C) is the combinational C-bit adder slice. It has inputs x, y, ci and outputs s, co, plus the carry into its MSB for overflow detection. It is instantiated once per stage via generate.

## Test plan
- SUB with N=32, STAGES=4: 5-3 gives result 2, carry_flag 0. 3-5 gives 0xFFFFFFFE, carry_flag 1, neg_flag 1.
- ADD 0xFFFFFFFF+1 gives 0, carry_flag 1, zero_flag 1. The same with sat_en=1, is_signed=0 gives 0xFFFFFFFF, zero_flag 0.
- Signed saturation: ADD 0x7FFFFFFF+1 gives 0x7FFFFFFF, ovf_flag 1. SUB 0x80000000-1 gives 0x80000000, ovf_flag 1.
- Cross-chunk carry: ADC 0x00FFFFFF+0 with cin=1 gives 0x01000000. SBB 0x01000000-0 with cin=1 gives 0x00FFFFFF, carry_flag 0. Both check that the result appears exactly 4 cycles after acceptance.
- Back-pressure: stream 16 operations with tags 0..15 while toggling out_ready pseudo-randomly.
  - All 16 results emerge in tag order with no loss or duplicates.
  - Outputs stay stable during stalls.
  - in_ready == (~out_valid | out_ready) every cycle.
- Reset mid-stream: with 3 operations in flight, pulse rst between clock edges. out_valid drops immediately, all outputs read 0, and no stale result appears after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and the saturation helper for the pipelined adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_t;

  // Widest datapath sat_value can serve; callers pass their real width in w.
  localparam int unsigned SAT_W = 128;

  // Final-stage result selection when saturation is enabled.
  // raw is the wrapped sum (zero-extended), c the internal carry (1 = no borrow
  // for SUB/SBB), ovf the signed overflow of raw, w the datapath width.
  function automatic logic [SAT_W-1:0] sat_value(
    input logic [SAT_W-1:0] raw,
    input logic             c,
    input logic             ovf,
    input op_t              op,
    input logic             is_signed,
    input int unsigned      w
  );
    logic [SAT_W-1:0] ones;
    logic [SAT_W-1:0] smin;
    logic             sub;
    ones = (SAT_W'(1) << w) - SAT_W'(1);
    smin = SAT_W'(1) << (w - 1);
    sub  = (op == OP_SUB) || (op == OP_SBB);
    sat_value = raw;
    if (is_signed) begin
      if (ovf) begin
        // raw MSB set means the true value went past the positive limit
        sat_value = raw[w-1] ? (smin - SAT_W'(1)) : smin;
      end
    end else begin
      if (!sub && c) begin
        sat_value = ones;
      end else if (sub && !c) begin
        sat_value = '0;
      end
    end
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational C-bit adder slice: one chunk of the split carry chain.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int unsigned C = 8
) (
  input  logic [C-1:0] x,
  input  logic [C-1:0] y,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co,
  output logic         cm
);

  logic [C:0] sum;

  // Full C-bit add with carry-in; carry into the MSB is recovered from the sum bit.
  always_comb begin
    sum = {1'b0, x} + {1'b0, y} + (C+1)'(ci);
  end

  assign s  = sum[C-1:0];
  assign co = sum[C];
  assign cm = x[C-1] ^ y[C-1] ^ sum[C-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: one carry-chain chunk per stage, shared
// advance enable for back-pressure, saturation and flags in the final stage.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             sat_en,
  input  logic             is_signed,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned C = N / STAGES;
  localparam int unsigned L = STAGES - 1;

  // Stage registers: index k holds the output of stage k.
  logic             v_q   [STAGES];
  op_t              op_q  [STAGES];
  logic             sat_q [STAGES];
  logic             sgn_q [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [N-1:0]     a_q   [STAGES];
  logic [N-1:0]     b_q   [STAGES];
  logic [N-1:0]     s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q, zero_q, neg_q;

  logic             v_d   [STAGES];
  op_t              op_d  [STAGES];
  logic             sat_d [STAGES];
  logic             sgn_d [STAGES];
  logic [TAG_W-1:0] tag_d [STAGES];
  logic [N-1:0]     a_d   [STAGES];
  logic [N-1:0]     b_d   [STAGES];
  logic [N-1:0]     s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d, zero_d, neg_d;

  // Stage inputs: ports for stage 0, previous stage registers otherwise.
  logic             st_v   [STAGES];
  op_t              st_op  [STAGES];
  logic             st_sat [STAGES];
  logic             st_sgn [STAGES];
  logic [TAG_W-1:0] st_tag [STAGES];
  logic [N-1:0]     st_a   [STAGES];
  logic [N-1:0]     st_b   [STAGES];
  logic [N-1:0]     st_s   [STAGES];
  logic             st_c   [STAGES];

  logic [C-1:0]     ch_s   [STAGES];
  logic             ch_co  [STAGES];
  logic             ch_cm  [STAGES];

  logic             adv;
  logic [N-1:0]     raw;
  logic [N-1:0]     fin;
  logic [SAT_W-1:0] sat_full;
  logic             sub_l;

  assign adv      = ~v_q[L] | out_ready;
  assign in_ready = adv;

  // Select each stage's operands; subtraction is folded in at entry as ~b plus carry-in.
  always_comb begin
    st_v[0]   = in_valid;
    st_op[0]  = op_t'(op);
    st_sat[0] = sat_en;
    st_sgn[0] = is_signed;
    st_tag[0] = tag;
    st_a[0]   = a;
    st_b[0]   = op[0] ? ~b : b;
    st_s[0]   = '0;
    st_c[0]   = 1'b0;
    case (op_t'(op))
      OP_ADD:  st_c[0] = 1'b0;
      OP_SUB:  st_c[0] = 1'b1;
      OP_ADC:  st_c[0] = cin;
      OP_SBB:  st_c[0] = ~cin;
      default: st_c[0] = 1'b0;
    endcase
    for (int unsigned k = 1; k < STAGES; k++) begin
      st_v[k]   = v_q[k-1];
      st_op[k]  = op_q[k-1];
      st_sat[k] = sat_q[k-1];
      st_sgn[k] = sgn_q[k-1];
      st_tag[k] = tag_q[k-1];
      st_a[k]   = a_q[k-1];
      st_b[k]   = b_q[k-1];
      st_s[k]   = s_q[k-1];
      st_c[k]   = c_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chunk
    addsub_chunk #(.C(C)) u_chunk (
      .x  (st_a[g][g*C +: C]),
      .y  (st_b[g][g*C +: C]),
      .ci (st_c[g]),
      .s  (ch_s[g]),
      .co (ch_co[g]),
      .cm (ch_cm[g])
    );
  end

  // Next-state: merge each chunk into the partial sum; the last stage
  // finishes flags and saturation and overwrites its sum/carry slots.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      v_d[k]   = st_v[k];
      op_d[k]  = st_op[k];
      sat_d[k] = st_sat[k];
      sgn_d[k] = st_sgn[k];
      tag_d[k] = st_tag[k];
      a_d[k]   = st_a[k];
      b_d[k]   = st_b[k];
      s_d[k]   = st_s[k];
      s_d[k][k*C +: C] = ch_s[k];
      c_d[k]   = ch_co[k];
    end
    raw      = s_d[L];
    sub_l    = (st_op[L] == OP_SUB) || (st_op[L] == OP_SBB);
    ovf_d    = ch_cm[L] ^ ch_co[L];
    sat_full = sat_value(SAT_W'(raw), ch_co[L], ovf_d, st_op[L], st_sgn[L], N);
    fin      = st_sat[L] ? sat_full[N-1:0] : raw;
    s_d[L]   = fin;
    c_d[L]   = sub_l ? ~ch_co[L] : ch_co[L];
    zero_d   = (fin == '0);
    neg_d    = fin[N-1];
  end

  // Whole pipeline advances together; nothing moves while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        op_q[k]  <= OP_ADD;
        sat_q[k] <= 1'b0;
        sgn_q[k] <= 1'b0;
        tag_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_d[k];
        op_q[k]  <= op_d[k];
        sat_q[k] <= sat_d[k];
        sgn_q[k] <= sgn_d[k];
        tag_q[k] <= tag_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign out_valid  = v_q[L];
  assign result     = s_q[L];
  assign carry_flag = c_q[L];
  assign ovf_flag   = ovf_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
  assign tag_out    = tag_q[L];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomized self-checking bench for pipelined_addsub (N=32, STAGES=4).
module tb_pipelined_addsub;

  localparam int unsigned N      = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a, b;
  logic             cin;
  logic [1:0]       op;
  logic             sat_en, is_signed;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             carry_flag, ovf_flag, zero_flag, neg_flag;
  logic [TAG_W-1:0] tag_out;

  pipelined_addsub #(.N(N), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .sat_en(sat_en), .is_signed(is_signed),
    .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_flag(carry_flag), .ovf_flag(ovf_flag), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;   // {carry, ovf, zero, neg}
    logic [3:0]  tg;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;
  bit   bp_en    = 0;
  bit   lat_chk  = 0;
  bit   stall_prev = 0;
  logic [31:0] hold_res;
  logic [8:0]  hold_misc;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then clamp by the saturation rules.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic ci, input logic sat, input logic sgn,
                           output logic [31:0] res, output logic [3:0] flags);
    logic [32:0] full;
    longint      sx, sy, st;
    logic        cflag, ovf, is_sub;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    is_sub = o[0];
    case (o)
      2'b00: begin full = {1'b0, x} + {1'b0, y};               st = sx + sy;              end
      2'b01: begin full = {1'b0, x} - {1'b0, y};               st = sx - sy;              end
      2'b10: begin full = {1'b0, x} + {1'b0, y} + 33'(ci);     st = sx + sy + longint'(ci); end
      default: begin full = {1'b0, x} - {1'b0, y} - 33'(ci);   st = sx - sy - longint'(ci); end
    endcase
    cflag = full[32];
    ovf   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    res   = full[31:0];
    if (sat) begin
      if (sgn) begin
        if (ovf) res = (st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else begin
        if (!is_sub && cflag) res = 32'hFFFF_FFFF;
        if (is_sub && cflag)  res = 32'h0000_0000;
      end
    end
    flags = {cflag, ovf, (res == 32'd0), res[31]};
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor and acceptance tracking, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mon_en) begin
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, ~out_valid | out_ready});
      if (stall_prev) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_result", {32'd0, result}, {32'd0, hold_res});
        check_eq("hold_flags_tag",
                 {55'd0, carry_flag, ovf_flag, zero_flag, neg_flag, 1'b0, tag_out},
                 {55'd0, hold_misc});
      end
      stall_prev = out_valid && !out_ready;
      hold_res   = result;
      hold_misc  = {carry_flag, ovf_flag, zero_flag, neg_flag, 1'b0, tag_out};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", {32'd0, result}, {32'd0, e.res});
          check_eq("flags", {60'd0, carry_flag, ovf_flag, zero_flag, neg_flag}, {60'd0, e.flags});
          check_eq("tag_order", {60'd0, tag_out}, {60'd0, e.tg});
          if (e.lat) check_eq("latency", 64'(cyc - e.acc_cyc), 64'(STAGES));
        end
      end
      if (in_valid && in_ready) begin
        ref_model(op, a, b, cin, sat_en, is_signed, e.res, e.flags);
        e.tg      = tag;
        e.acc_cyc = cyc;
        e.lat     = lat_chk;
        exp_q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic s, input logic sg, input logic [3:0] tg);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1'b1; op = o; a = x; b = y; cin = ci; sat_en = s; is_signed = sg; tag = tg;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) check_eq("issue_timeout", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [6];
    edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'h00FF_FFFF; edges[5] = 32'h0000_0001;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  task automatic check_outputs_zero(input string name);
    check_eq({name, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({name, "_result"}, {32'd0, result}, 64'd0);
    check_eq({name, "_flags_tag"},
             {56'd0, carry_flag, ovf_flag, zero_flag, neg_flag, tag_out}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00;
    sat_en = 1'b0; is_signed = 1'b0; tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", {63'd0, in_ready}, 64'd1);
    mon_en = 1;

    // Directed corner cases, full-rate, with latency checked.
    lat_chk = 1;
    issue(2'b01, 32'd5, 32'd3, 1'b1, 1'b0, 1'b0, 4'd1);
    issue(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 4'd2);
    issue(2'b00, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 4'd3);
    issue(2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 4'd4);
    issue(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 4'd5);
    issue(2'b01, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, 4'd6);
    issue(2'b10, 32'h00FF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, 4'd7);
    issue(2'b11, 32'h0100_0000, 32'd0, 1'b1, 1'b0, 1'b0, 4'd8);
    issue(2'b01, 32'd3, 32'd5, 1'b0, 1'b1, 1'b0, 4'd9);
    drain();

    // Back-pressure stream, tags 0..15.
    lat_chk = 0;
    bp_en = 1;
    for (int i = 0; i < 16; i++) begin
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
    end
    drain();

    // Longer random stream with random tags and idle gaps.
    for (int i = 0; i < 120; i++) begin
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp_en = 0;
    drain();

    // Reset mid-stream: one result at the output, three behind it.
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 32'(i + 10), 32'd100, 1'b0, 1'b0, 1'b0, 4'(i + 12));
    end
    check_eq("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    check_eq("mid_reset_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    stall_prev = 0;
    #1 rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      check_eq("post_reset_no_output", {63'd0, out_valid}, 64'd0);
    end

    // Pipeline still works after the reset.
    lat_chk = 1;
    issue(2'b10, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 4'd15);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
